button_event_ctrl: RTL

Multi-button input controller that debounces N raw push-buttons against a single shared millisecond sampling tick and turns their stable levels into discrete events: press, long-press, auto-repeat and release. Pending events from all buttons are arbitrated round-robin onto one valid/ready event port. The block sits between the board's pushbuttons and whichever menu or FSM consumes user input, and replaces per-button debouncer and clock-divider instances.

---
 rtl/button_event_ctrl.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/button_event_ctrl.sv
// Debounces N push-buttons on a shared sampling tick and turns their stable
// levels into PRESS / LONG / REPEAT / RELEASE events on one round-robin event port.
module button_event_ctrl #(
    parameter int N_BUTTONS      = 4,
    parameter int CLK_FREQ       = 50_000_000,
    parameter int SAMPLE_MS      = 1,
    parameter int STABLE_SAMPLES = 4,
    parameter int LONG_MS        = 1000,
    parameter int REPEAT_MS      = 200,
    parameter bit BTN_ACTIVE_LOW = 1'b0,
    localparam int IDW = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_a_p,
    input  logic [N_BUTTONS-1:0]   btn_raw,
    output logic [N_BUTTONS-1:0]   btn_level,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [IDW-1:0]         evt_id,
    output logic [1:0]             evt_type,
    output logic                   overrun,
    output logic [2*N_BUTTONS-1:0] dbg_state
);

    localparam int TICK_DIV = CLK_FREQ / 1000 * SAMPLE_MS;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LONG_T   = LONG_MS / SAMPLE_MS;
    localparam int REP_T    = REPEAT_MS / SAMPLE_MS;
    localparam int SW       = $clog2(STABLE_SAMPLES + 1);
    localparam int HW       = (LONG_T > 0) ? $clog2(LONG_T + 1) : 1;
    localparam int RW       = (REP_T > 0) ? $clog2(REP_T + 1) : 1;
    localparam int AW       = IDW + 1;

    typedef enum logic [1:0] {
        ST_UP   = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [N_BUTTONS-1:0] sync1, sync2, s;
    logic [SW-1:0]        scnt [N_BUTTONS];
    logic [N_BUTTONS-1:0] flip, rise, fall;
    state_t               state_q [N_BUTTONS];
    state_t               state_d [N_BUTTONS];
    logic [HW-1:0]        hcnt [N_BUTTONS];
    logic [RW-1:0]        rcnt [N_BUTTONS];
    logic [N_BUTTONS-1:0] long_hit, rep_hit;
    logic [3:0]           raise [N_BUTTONS];
    logic [3:0]           pend  [N_BUTTONS];
    logic [3:0]           clr   [N_BUTTONS];
    logic                 lost;
    logic [IDW-1:0]       rr_ptr;
    logic                 grant_any;
    logic [IDW-1:0]       grant_id;
    logic [1:0]           grant_type;
    logic [AW-1:0]        arb_sum;
    logic [IDW-1:0]       arb_idx;
    logic                 load;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst_a_p || tick) tick_cnt <= '0;
        else                 tick_cnt <= tick_cnt + 1'b1;
    end

    // Synchronizer is left out of reset so a button held through reset is seen at once.
    always_ff @(posedge clk) begin
        sync1 <= btn_raw;
        sync2 <= sync1;
    end

    assign s = sync2 ^ {N_BUTTONS{BTN_ACTIVE_LOW}};

    always_comb begin
        for (int i = 0; i < N_BUTTONS; i++)
            flip[i] = tick && (s[i] != btn_level[i]) && (scnt[i] == SW'(STABLE_SAMPLES - 1));
    end

    assign rise = flip & ~btn_level;
    assign fall = flip & btn_level;

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            btn_level <= '0;
            for (int i = 0; i < N_BUTTONS; i++) scnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (flip[i]) begin
                    btn_level[i] <= ~btn_level[i];
                    scnt[i]      <= '0;
                end else if (s[i] != btn_level[i]) begin
                    scnt[i] <= scnt[i] + 1'b1;
                end else begin
                    scnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_BUTTONS; i++) begin
            long_hit[i] = (int'(hcnt[i]) + 1 == LONG_T);
            rep_hit[i]  = (int'(rcnt[i]) + 1 == REP_T);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            for (int i = 0; i < N_BUTTONS; i++) state_q[i] <= ST_UP;
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) state_q[i] <= state_d[i];
        end
    end

    // A release on the same tick as a LONG/REPEAT deadline wins.
    always_comb begin
        for (int i = 0; i < N_BUTTONS; i++) begin
            state_d[i] = state_q[i];
            if (tick) begin
                case (state_q[i])
                    ST_UP:   if (rise[i]) state_d[i] = ST_DOWN;
                    ST_DOWN: begin
                        if (fall[i])          state_d[i] = ST_UP;
                        else if (long_hit[i]) state_d[i] = ST_HELD;
                    end
                    ST_HELD: if (fall[i]) state_d[i] = ST_UP;
                    default: state_d[i] = ST_UP;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_BUTTONS; i++) begin
            raise[i] = 4'b0000;
            if (tick) begin
                case (state_q[i])
                    ST_UP:   raise[i][0] = rise[i];
                    ST_DOWN: begin
                        if (fall[i])          raise[i][3] = 1'b1;
                        else if (long_hit[i]) raise[i][1] = 1'b1;
                    end
                    ST_HELD: begin
                        if (fall[i])         raise[i][3] = 1'b1;
                        else if (rep_hit[i]) raise[i][2] = 1'b1;
                    end
                    default: raise[i] = 4'b0000;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_BUTTONS; i++) dbg_state[2*i +: 2] = state_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                hcnt[i] <= '0;
                rcnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                case (state_q[i])
                    ST_DOWN: begin
                        hcnt[i] <= hcnt[i] + 1'b1;
                        rcnt[i] <= '0;
                    end
                    ST_HELD: rcnt[i] <= rep_hit[i] ? '0 : rcnt[i] + 1'b1;
                    default: begin
                        hcnt[i] <= '0;
                        rcnt[i] <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        grant_any  = 1'b0;
        grant_id   = '0;
        grant_type = 2'd0;
        arb_sum    = '0;
        arb_idx    = '0;
        for (int k = 0; k < N_BUTTONS; k++) begin
            arb_sum = {1'b0, rr_ptr} + AW'(k);
            if (arb_sum >= AW'(N_BUTTONS)) arb_sum = arb_sum - AW'(N_BUTTONS);
            arb_idx = arb_sum[IDW-1:0];
            if (!grant_any && (|pend[arb_idx])) begin
                grant_any = 1'b1;
                grant_id  = arb_idx;
                if (pend[arb_idx][0])      grant_type = 2'd0;
                else if (pend[arb_idx][1]) grant_type = 2'd1;
                else if (pend[arb_idx][2]) grant_type = 2'd2;
                else                       grant_type = 2'd3;
            end
        end
    end

    // Event port: a beat transfers on a clk edge with evt_valid && evt_ready; while
    // evt_valid is high and evt_ready low, evt_id/evt_type hold and a new grant waits.
    assign load = grant_any && (!evt_valid || evt_ready);

    always_comb begin
        for (int i = 0; i < N_BUTTONS; i++) clr[i] = 4'b0000;
        if (load) clr[grant_id][grant_type] = 1'b1;
    end

    always_comb begin
        lost = 1'b0;
        for (int i = 0; i < N_BUTTONS; i++) lost = lost | (|(raise[i] & pend[i] & ~clr[i]));
    end

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            for (int i = 0; i < N_BUTTONS; i++) pend[i] <= 4'b0000;
            overrun <= 1'b0;
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) pend[i] <= (pend[i] & ~clr[i]) | raise[i];
            if (lost) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_type  <= 2'd0;
            rr_ptr    <= '0;
        end else if (!evt_valid || evt_ready) begin
            evt_valid <= grant_any;
            if (grant_any) begin
                evt_id   <= grant_id;
                evt_type <= grant_type;
                rr_ptr   <= (grant_id == IDW'(N_BUTTONS - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

endmodule
